// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The handshake state enum, the legal access-size codes and the wait-counter width
// live here so the top level and the bench-facing code agree on them.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } dmemState_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    localparam int CNT_WIDTH = 4;

    // Only the three right-aligned size codes describe a real access.
    function automatic logic isLegalBe(input logic [3:0] be);
        return (be == BE_BYTE) || (be == BE_HALF) || (be == BE_WORD);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering between right-aligned CPU data and the
// memory word: builds the lane write mask, shifts write data into its lanes and
// pulls read data back down to bit 0 with unselected bytes cleared.
module dmem_lane_align (
    input  logic [3:0]  be_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  laneMask_o,
    output logic [31:0] wdataShifted_o,
    output logic [31:0] rdata_o
);

    logic [31:0] beExpanded;
    logic [4:0]  bitShift;

    // Expand the size code to a byte mask and shift everything by the byte offset.
    always_comb begin
        bitShift = {offset_i, 3'b000};
        for (int b = 0; b < 4; b++) begin
            beExpanded[8*b +: 8] = {8{be_i[b]}};
        end
        laneMask_o     = be_i << offset_i;
        wdataShifted_o = wdata_i << bitShift;
        rdata_o        = (word_i >> bitShift) & beExpanded;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the multicycle CPU.
// Accepts a level-held MemRead/MemWrite request, waits WAIT_CYCLES cycles,
// pulses MemReady for one cycle and then waits for the request to drop.
// Build option: DMEM_MISALIGN_CHECK_EN rejects misaligned half/word accesses;
// without it those accesses are silently aligned down to their natural boundary.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [3:0]  BE,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        MemReady,
    output logic        Busy,
    output logic        Err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : CNT_WIDTH'(WAIT_CYCLES - 1);

    dmemState_e           stateQ, stateD;
    logic [CNT_WIDTH-1:0] cntQ, cntD;
    logic [AW+1:0]        addrQ;
    logic [3:0]           beQ;
    logic [31:0]          wdataQ;
    logic                 isWriteQ;
    logic                 bothQ;
    logic [31:0]          rdataQ, rdataD;

    logic                 request;
    logic                 accept;
    logic                 misalign;
    logic                 reject;
    logic [1:0]           effOffset;
    logic [AW-1:0]        wordIdx;
    logic [3:0]           laneMask;
    logic [31:0]          wdataShifted;
    logic [31:0]          rdataAligned;

    logic [31:0]          mem [DEPTH_WORDS];

    assign request = MemRead | MemWrite;
    assign accept  = (stateQ == IDLE) && request;
    assign wordIdx = addrQ[AW+1:2];

    // Classify the latched access and pick the byte offset actually used for steering.
    always_comb begin
        misalign  = 1'b0;
        effOffset = addrQ[1:0];
`ifdef DMEM_MISALIGN_CHECK_EN
        misalign = ((beQ == BE_HALF) && addrQ[0]) ||
                   ((beQ == BE_WORD) && (addrQ[1:0] != 2'b00));
`else
        if (beQ == BE_WORD) begin
            effOffset = 2'b00;
        end else if (beQ == BE_HALF) begin
            effOffset = {addrQ[1], 1'b0};
        end
`endif
        reject = bothQ || !isLegalBe(beQ) || misalign;
    end

    dmem_lane_align uLaneAlign (
        .be_i           (beQ),
        .offset_i       (effOffset),
        .word_i         (mem[wordIdx]),
        .wdata_i        (wdataQ),
        .laneMask_o     (laneMask),
        .wdataShifted_o (wdataShifted),
        .rdata_o        (rdataAligned)
    );

    // Handshake state register; reset always returns to IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic: accept, count wait states, respond once, then wait for release.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE: if (request) stateD = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (cntQ == '0) stateD = RESP;
            RESP: stateD = HOLD;
            HOLD: if (!request) stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // Outputs: ready/error during the response cycle; RDATA refreshes on reads and rejects only.
    always_comb begin
        MemReady = (stateQ == RESP);
        Busy     = (stateQ != IDLE);
        Err      = (stateQ == RESP) && reject;
        rdataD   = rdataQ;
        if (stateQ == RESP) begin
            if (reject) begin
                rdataD = '0;
            end else if (!isWriteQ) begin
                rdataD = rdataAligned;
            end
        end
        RDATA = rdataD;
    end

    // Wait counter: loaded on accept, counts down while waiting.
    always_comb begin
        cntD = cntQ;
        if (accept) begin
            cntD = CNT_LOAD;
        end else if ((stateQ == WAIT) && (cntQ != '0)) begin
            cntD = cntQ - 1'b1;
        end
    end

    // Counter, request latches and held read data; later input changes are ignored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cntQ     <= '0;
            addrQ    <= '0;
            beQ      <= '0;
            wdataQ   <= '0;
            isWriteQ <= 1'b0;
            bothQ    <= 1'b0;
            rdataQ   <= '0;
        end else begin
            cntQ   <= cntD;
            rdataQ <= rdataD;
            if (accept) begin
                addrQ    <= ADDR[AW+1:0];
                beQ      <= BE;
                wdataQ   <= WDATA;
                isWriteQ <= MemWrite;
                bothQ    <= MemRead & MemWrite;
            end
        end
    end

    // Lane write at the end of the response cycle; a reset in that cycle drops the write.
    always_ff @(posedge CLK) begin
        if (!RST && (stateQ == RESP) && isWriteQ && !reject) begin
            for (int b = 0; b < 4; b++) begin
                if (laneMask[b]) begin
                    mem[wordIdx][8*b +: 8] <= wdataShifted[8*b +: 8];
                end
            end
        end
    end

endmodule
